// File: rtl/tug_if.sv
// Tug-of-war round controller bus: player pulses in, rope/score/status out.
// The controller uses the slave modport; the player/input side uses master.
interface tug_if #(
  parameter int POS_W = 4,
  parameter int SC_W  = 2
);
  logic             start;
  logic             push_l;
  logic             push_r;
  logic [POS_W-1:0] pos;
  logic [1:0]       state;
  logic             round_active;
  logic             win_l;
  logic             win_r;
  logic [SC_W-1:0]  score_l;
  logic [SC_W-1:0]  score_r;
  logic             match_over;
  logic             foul_l;
  logic             foul_r;

  modport master (
    output start, push_l, push_r,
    input  pos, state, round_active, win_l, win_r,
    input  score_l, score_r, match_over, foul_l, foul_r
  );

  modport slave (
    input  start, push_l, push_r,
    output pos, state, round_active, win_l, win_r,
    output score_l, score_r, match_over, foul_l, foul_r
  );
endinterface

// File: rtl/tug_round_ctrl.sv
// Tug-of-war round sequencer and push arbiter.
// Owns rope position, countdown, round winner and match score.
// Optional feature macro TUG_FOUL_EN: a push during the countdown is a false
// start (offender flagged, opponent awarded the round). Without it, countdown
// pushes are ignored and the foul outputs stay 0.
module tug_round_ctrl #(
  parameter int HALF       = 4,
  parameter int POS_W      = 4,
  parameter int CD_CYCLES  = 8,
  parameter int MATCH_WINS = 3,
  parameter int SC_W       = 2
) (
  input logic   clk,
  input logic   rst,
  tug_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CDOWN    = 2'b01,
    PLAY     = 2'b10,
    WIN_OVER = 2'b11
  } state_t;

  localparam int CNT_W = (CD_CYCLES > 1) ? $clog2(CD_CYCLES) : 1;
  localparam logic [POS_W-1:0] CENTRE  = POS_W'(HALF);
  localparam logic [POS_W-1:0] TOP     = POS_W'(2 * HALF);
  localparam logic [SC_W-1:0]  WINS    = SC_W'(MATCH_WINS);
  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(CD_CYCLES - 1);

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [POS_W-1:0] pos_q, pos_nx;
  logic             active_q, active_nx;
  logic             win_l_q, win_l_nx, win_r_q, win_r_nx;
  logic [SC_W-1:0]  score_l_q, score_l_nx, score_r_q, score_r_nx;
  logic             match_q, match_nx;
  logic             foul_l_q, foul_l_nx, foul_r_q, foul_r_nx;
  logic [SC_W-1:0]  inc_l, inc_r;

  // State and output registers; reset is asynchronous and immediate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_W'(0);
      pos_q     <= CENTRE;
      active_q  <= 1'b0;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      score_l_q <= SC_W'(0);
      score_r_q <= SC_W'(0);
      match_q   <= 1'b0;
      foul_l_q  <= 1'b0;
      foul_r_q  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      pos_q     <= pos_nx;
      active_q  <= active_nx;
      win_l_q   <= win_l_nx;
      win_r_q   <= win_r_nx;
      score_l_q <= score_l_nx;
      score_r_q <= score_r_nx;
      match_q   <= match_nx;
      foul_l_q  <= foul_l_nx;
      foul_r_q  <= foul_r_nx;
    end
  end

  // Next-state logic: round sequencing, push arbitration and scoring.
  always_comb begin
    state_nx   = state_q;
    cnt_nx     = cnt_q;
    pos_nx     = pos_q;
    win_l_nx   = win_l_q;
    win_r_nx   = win_r_q;
    score_l_nx = score_l_q;
    score_r_nx = score_r_q;
    match_nx   = match_q;
    foul_l_nx  = foul_l_q;
    foul_r_nx  = foul_r_q;
    inc_l      = score_l_q + SC_W'(1);
    inc_r      = score_r_q + SC_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nx = CDOWN;
          cnt_nx   = CD_LOAD;
          pos_nx   = CENTRE;
        end else begin
          state_nx = IDLE;
        end
      end

      CDOWN: begin
`ifdef TUG_FOUL_EN
        if (bus.push_l && bus.push_r) begin
          foul_l_nx = 1'b1;
          foul_r_nx = 1'b1;
          state_nx  = WIN_OVER;
        end else if (bus.push_l) begin
          foul_l_nx  = 1'b1;
          win_r_nx   = 1'b1;
          score_r_nx = inc_r;
          match_nx   = (inc_r == WINS);
          state_nx   = WIN_OVER;
        end else if (bus.push_r) begin
          foul_r_nx  = 1'b1;
          win_l_nx   = 1'b1;
          score_l_nx = inc_l;
          match_nx   = (inc_l == WINS);
          state_nx   = WIN_OVER;
        end else
`endif
        if (cnt_q == CNT_W'(0)) begin
          state_nx = PLAY;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end

      PLAY: begin
        if (bus.push_r && !bus.push_l) begin
          pos_nx = pos_q + POS_W'(1);
          if (pos_q + POS_W'(1) == TOP) begin
            win_r_nx   = 1'b1;
            score_r_nx = inc_r;
            match_nx   = (inc_r == WINS);
            state_nx   = WIN_OVER;
          end else begin
            state_nx = PLAY;
          end
        end else if (bus.push_l && !bus.push_r) begin
          pos_nx = pos_q - POS_W'(1);
          if (pos_q == POS_W'(1)) begin
            win_l_nx   = 1'b1;
            score_l_nx = inc_l;
            match_nx   = (inc_l == WINS);
            state_nx   = WIN_OVER;
          end else begin
            state_nx = PLAY;
          end
        end else begin
          state_nx = PLAY;
        end
      end

      WIN_OVER: begin
        if (bus.start) begin
          win_l_nx  = 1'b0;
          win_r_nx  = 1'b0;
          foul_l_nx = 1'b0;
          foul_r_nx = 1'b0;
          pos_nx    = CENTRE;
          cnt_nx    = CD_LOAD;
          state_nx  = CDOWN;
          if (match_q) begin
            score_l_nx = SC_W'(0);
            score_r_nx = SC_W'(0);
            match_nx   = 1'b0;
          end else begin
            match_nx = 1'b0;
          end
        end else begin
          state_nx = WIN_OVER;
        end
      end

      default: begin
        state_nx = IDLE;
        pos_nx   = CENTRE;
      end
    endcase

    active_nx = (state_nx == PLAY);
  end

  assign bus.pos          = pos_q;
  assign bus.state        = state_q;
  assign bus.round_active = active_q;
  assign bus.win_l        = win_l_q;
  assign bus.win_r        = win_r_q;
  assign bus.score_l      = score_l_q;
  assign bus.score_r      = score_r_q;
  assign bus.match_over   = match_q;
  assign bus.foul_l       = foul_l_q;
  assign bus.foul_r       = foul_r_q;

endmodule
